// File: rtl/instr_exec.sv
// Execution stage for the 11-bit instruction stream. Each strobed word is
// captured, then goes through decode, execute and write-back against a
// 4-entry register file. Results are also reflected in out_data and the
// zero and carry flags.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for instr_valid; a strobe latches the word
// DECODE | read R[rd] and R[rs] into the operand registers
// EXEC   | ALU result and next carry captured into registers
// WB     | commit to R[rd] / out_data and the flags; done pulses next cycle
module instr_exec #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       instr,
    input  logic              instr_valid,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              zero,
    output logic              carry,
    output logic              dropped
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_OUT = 3'b111;

    state_t            state;
    state_t            state_nxt;
    logic [10:0]       instr_q;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] res_q;
    logic              carry_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   sum;

    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [5:0] imm;

    assign op  = instr_q[10:8];
    assign rd  = instr_q[7:6];
    assign imm = instr_q[5:0];
    assign rs  = instr_q[1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; each instruction always walks the full sequence
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ALU on the latched operands; NOP/OUT pass opa through and do not touch flags
    always_comb begin
        sum       = {1'b0, opa} + {1'b0, opb};
        alu_res   = opa;
        alu_carry = 1'b0;
        case (op)
            OP_LDI: alu_res = DATA_W'(imm);
            OP_ADD: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res   = opa - opb;
                alu_carry = (opa < opb);
            end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_SHL: alu_res = opa << imm[2:0];
            default: alu_res = opa;
        endcase
    end

    // Datapath: latch, operand read, result capture, write-back and status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q  <= '0;
            regs     <= '{default: '0};
            opa      <= '0;
            opb      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_data <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state == S_WB);
            if (instr_valid && (state != S_IDLE)) begin
                dropped <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                S_DECODE: begin
                    opa <= regs[rd];
                    opb <= regs[rs];
                end
                S_EXEC: begin
                    res_q   <= alu_res;
                    carry_q <= alu_carry;
                end
                S_WB: begin
                    if (op == OP_OUT) begin
                        out_data <= opa;
                    end else if (op != OP_NOP) begin
                        regs[rd] <= res_q;
                        zero     <= (res_q == '0);
                        carry    <= carry_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec.sv
// Self-checking bench for instr_exec. A behavioural register-file model
// computes every expected output with plain integer arithmetic.
module tb_instr_exec;

    logic        clk;
    logic        reset;
    logic [10:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic [7:0]  out_data;
    logic        zero;
    logic        carry;
    logic        dropped;

    int n_checks = 0;
    int n_errors = 0;

    int m_regs [4];
    int m_out;
    int m_zero;
    int m_carry;
    int m_dropped;

    instr_exec #(.DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .out_data    (out_data),
        .zero        (zero),
        .carry       (carry),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [10:0] mk(input int op, input int rd, input int imm);
        logic [10:0] w;
        w[10:8] = op[2:0];
        w[7:6]  = rd[1:0];
        w[5:0]  = imm[5:0];
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_out = 0; m_zero = 0; m_carry = 0; m_dropped = 0;
    endfunction

    function automatic void model_apply(input logic [10:0] w);
        int op, rd, rs, imm, a, b, r, c;
        op  = int'(w[10:8]);
        rd  = int'(w[7:6]);
        imm = int'(w[5:0]);
        rs  = imm % 4;
        a   = m_regs[rd];
        b   = m_regs[rs];
        r   = 0;
        c   = 0;
        case (op)
            1: r = imm;
            2: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            3: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            4: r = a & b;
            5: r = a | b;
            6: r = (a * (1 << (imm % 8))) % 256;
            7: m_out = a;
            default: ;
        endcase
        if (op >= 1 && op <= 6) begin
            m_regs[rd] = r;
            m_zero     = (r == 0) ? 1 : 0;
            m_carry    = c;
        end
    endfunction

    // Starts on a falling edge with the DUT idle; ends on the falling edge
    // where done is high, so the next call can strobe immediately.
    task automatic exec_instr(input logic [10:0] w);
        instr = w;
        instr_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr = 11'($urandom);
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_window instr=%h cyc%0d: busy=%b done=%b, want busy=1 done=0", w, c, busy, done);
            end
        end
        @(negedge clk);
        model_apply(w);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL retire instr=%h: busy=%b done=%b, want busy=0 done=1", w, busy, done);
        end
        n_checks++;
        if (out_data !== 8'(m_out)) begin
            n_errors++;
            $display("FAIL out_data instr=%h: got %0d want %0d", w, out_data, m_out);
        end
        n_checks++;
        if (zero !== 1'(m_zero) || carry !== 1'(m_carry)) begin
            n_errors++;
            $display("FAIL flags instr=%h: zero=%b carry=%b want zero=%0d carry=%0d", w, zero, carry, m_zero, m_carry);
        end
        n_checks++;
        if (dropped !== 1'(m_dropped)) begin
            n_errors++;
            $display("FAIL dropped instr=%h: got %b want %0d", w, dropped, m_dropped);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, out_data, zero, carry, dropped} !== 13'd0) begin
                n_errors++;
                $display("FAIL reset_idle cyc%0d: busy=%b done=%b out=%0d z=%b c=%b d=%b, want all 0",
                         i, busy, done, out_data, zero, carry, dropped);
            end
        end
    endtask

    task automatic test_basic();
        exec_instr(mk(1, 1, 5));
        exec_instr(mk(1, 2, 3));
        exec_instr(mk(2, 1, 2));
        exec_instr(mk(7, 1, 0));
        n_checks++;
        if (out_data !== 8'd8 || zero !== 1'b0 || carry !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_add: out=%0d z=%b c=%b want 8 0 0", out_data, zero, carry);
        end
    endtask

    task automatic test_shift_carry();
        exec_instr(mk(1, 0, 63));
        exec_instr(mk(6, 0, 2));
        exec_instr(mk(7, 0, 0));
        n_checks++;
        if (out_data !== 8'hFC) begin
            n_errors++;
            $display("FAIL shl: out=%h want fc", out_data);
        end
        exec_instr(mk(2, 0, 0));
        n_checks++;
        if (carry !== 1'b1) begin
            n_errors++;
            $display("FAIL add_carry: carry=%b want 1", carry);
        end
        exec_instr(mk(7, 0, 0));
        n_checks++;
        if (out_data !== 8'hF8) begin
            n_errors++;
            $display("FAIL add_self: out=%h want f8", out_data);
        end
    endtask

    task automatic test_sub();
        exec_instr(mk(1, 3, 2));
        exec_instr(mk(1, 2, 5));
        exec_instr(mk(3, 3, 2));
        n_checks++;
        if (carry !== 1'b1 || zero !== 1'b0) begin
            n_errors++;
            $display("FAIL sub_borrow: z=%b c=%b want z=0 c=1", zero, carry);
        end
        exec_instr(mk(7, 3, 0));
        n_checks++;
        if (out_data !== 8'hFD) begin
            n_errors++;
            $display("FAIL sub_value: out=%h want fd", out_data);
        end
        exec_instr(mk(3, 3, 3));
        n_checks++;
        if (zero !== 1'b1 || carry !== 1'b0) begin
            n_errors++;
            $display("FAIL sub_self: z=%b c=%b want z=1 c=0", zero, carry);
        end
    endtask

    task automatic test_nop();
        logic [7:0] o;
        logic       z, c;
        o = out_data; z = zero; c = carry;
        exec_instr(mk(0, 2, 17));
        n_checks++;
        if (out_data !== o || zero !== z || carry !== c) begin
            n_errors++;
            $display("FAIL nop_hold: out=%0d z=%b c=%b want %0d %b %b", out_data, zero, carry, o, z, c);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin instr = mk(1, 2, 7); instr_valid = 1'b1; end
            if (c == 2) begin instr = mk(1, 2, 1); instr_valid = 1'b1; end
            @(negedge clk);
            instr_valid = 1'b0;
            if (done === 1'b1) done_cnt++;
        end
        model_apply(mk(1, 2, 7));
        m_dropped = 1;
        n_checks++;
        if (done_cnt != 1) begin
            n_errors++;
            $display("FAIL drop_done_count: got %0d want 1", done_cnt);
        end
        n_checks++;
        if (dropped !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_flag: got %b want 1", dropped);
        end
        exec_instr(mk(7, 2, 0));
        n_checks++;
        if (out_data !== 8'd7) begin
            n_errors++;
            $display("FAIL drop_value: out=%0d want 7", out_data);
        end
    endtask

    task automatic test_reset_mid();
        exec_instr(mk(1, 1, 9));
        exec_instr(mk(7, 1, 0));
        instr = mk(1, 1, 20);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({busy, done, out_data, zero, carry, dropped} !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_mid: busy=%b done=%b out=%0d z=%b c=%b d=%b, want all 0",
                     busy, done, out_data, zero, carry, dropped);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_quiet cyc%0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        exec_instr(mk(7, 1, 0));
    endtask

    task automatic test_random();
        int op, rd, imm;
        for (int i = 0; i < 30; i++) begin
            op  = int'($urandom_range(0, 6));
            rd  = int'($urandom_range(0, 3));
            imm = int'($urandom_range(0, 63));
            exec_instr(mk(op, rd, imm));
            exec_instr(mk(7, rd, int'($urandom_range(0, 63))));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift_carry();
        test_sub();
        test_nop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
